// File: rtl/led_seq_pkg.sv
// ============================================================================
// led_seq_pkg : mode encodings, bounce-direction flag and reset pattern constants
// Revision    : 1.0
// ============================================================================
`default_nettype none

package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_ROTATE = 2'd0,
    MODE_BOUNCE = 2'd1,
    MODE_FILL   = 2'd2,
    MODE_BINARY = 2'd3
  } led_mode_e;

  typedef enum logic {
    BOUNCE_UP   = 1'b0,
    BOUNCE_DOWN = 1'b1
  } bounce_dir_e;

  // led0 is the lit LED after reset and after a reload into a one-hot mode.
  localparam logic RESET_LED0 = 1'b1;
  localparam logic RELOAD_FILL_LED0 = 1'b0;

  function automatic logic reload_is_empty(input logic [1:0] m);
    return (m == MODE_FILL);
  endfunction

endpackage : led_seq_pkg

`default_nettype wire

// File: rtl/led_tick_gen.sv
// ============================================================================
// led_tick_gen : free-running prescaler, one tick every period+1 enabled cycles
// Revision     : 1.0
// ============================================================================
`default_nettype none

module led_tick_gen #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] period,
  output logic             tick
);

  logic [CNT_W-1:0] r_pc;
  logic             w_wrap;

  // >= rather than == so that shrinking period below the current count
  // fires immediately instead of waiting for a full counter wrap.
  assign w_wrap = (r_pc >= period);
  assign tick   = en && w_wrap;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= '0;
    end else if (clr) begin
      r_pc <= '0;
    end else if (en) begin
      if (w_wrap) begin
        r_pc <= '0;
      end else begin
        r_pc <= r_pc + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule : led_tick_gen

`default_nettype wire

// File: rtl/led_pattern_sequencer.sv
// ============================================================================
// led_pattern_sequencer : N-LED rotate / bounce / fill / binary sequencer
// Revision              : 1.0
// ============================================================================
`default_nettype none

module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int N_LEDS = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              dir,
  input  logic              hold,
  input  logic [1:0]        mode,
  input  logic [CNT_W-1:0]  period,
  output logic [N_LEDS-1:0] leds,
  output logic              step
);

  localparam logic [N_LEDS-1:0] C_ONE    = {{(N_LEDS-1){1'b0}}, RESET_LED0};
  localparam logic [N_LEDS-1:0] C_EMPTY  = {{(N_LEDS-1){1'b0}}, RELOAD_FILL_LED0};
  localparam logic [N_LEDS-1:0] C_ONES   = {N_LEDS{1'b1}};

  logic [N_LEDS-1:0] r_leds;
  logic              r_step;
  bounce_dir_e       r_bounce;
  logic [1:0]        r_last_mode;

  logic              w_tick;
  logic              w_mode_chg;
  logic              w_advance;
  logic              w_onehot;
  logic [N_LEDS-1:0] w_next_leds;
  bounce_dir_e       w_next_bounce;

  assign w_mode_chg = (mode != r_last_mode);
  assign w_advance  = w_tick && !hold;
  assign w_onehot   = (r_leds != '0) && ((r_leds & (r_leds - C_ONE)) == '0);

  led_tick_gen #(
    .CNT_W (CNT_W)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .clr    (w_mode_chg),
    .period (period),
    .tick   (w_tick)
  );

  always_comb begin
    w_next_leds   = r_leds;
    w_next_bounce = r_bounce;
    case (mode)
      MODE_ROTATE: begin
        if (!w_onehot) begin
          w_next_leds = C_ONE;
        end else if (!dir) begin
          w_next_leds = {r_leds[N_LEDS-2:0], r_leds[N_LEDS-1]};
        end else begin
          w_next_leds = {r_leds[0], r_leds[N_LEDS-1:1]};
        end
      end
      MODE_BOUNCE: begin
        // The flag flips on the step that leaves an end LED, so each end
        // is shown for exactly one step.
        if (!w_onehot) begin
          w_next_leds   = C_ONE;
          w_next_bounce = BOUNCE_UP;
        end else if (r_bounce == BOUNCE_UP) begin
          if (r_leds[N_LEDS-1]) begin
            w_next_leds   = r_leds >> 1;
            w_next_bounce = BOUNCE_DOWN;
          end else begin
            w_next_leds = r_leds << 1;
          end
        end else begin
          if (r_leds[0]) begin
            w_next_leds   = r_leds << 1;
            w_next_bounce = BOUNCE_UP;
          end else begin
            w_next_leds = r_leds >> 1;
          end
        end
      end
      MODE_FILL: begin
        if (r_leds == C_ONES) begin
          w_next_leds = '0;
        end else if (!dir) begin
          w_next_leds = {r_leds[N_LEDS-2:0], 1'b1};
        end else begin
          w_next_leds = {1'b1, r_leds[N_LEDS-1:1]};
        end
      end
      MODE_BINARY: begin
        w_next_leds = dir ? (r_leds - C_ONE) : (r_leds + C_ONE);
      end
      default: begin
        w_next_leds = C_ONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_leds      <= C_ONE;
      r_step      <= 1'b0;
      r_bounce    <= BOUNCE_UP;
      r_last_mode <= mode;
    end else if (w_mode_chg) begin
      r_leds      <= reload_is_empty(mode) ? C_EMPTY : C_ONE;
      r_step      <= 1'b1;
      r_bounce    <= BOUNCE_UP;
      r_last_mode <= mode;
    end else if (w_advance) begin
      r_leds   <= w_next_leds;
      r_step   <= 1'b1;
      r_bounce <= w_next_bounce;
    end else begin
      r_step <= 1'b0;
    end
  end

  assign leds = r_leds;
  assign step = r_step;

endmodule : led_pattern_sequencer

`default_nettype wire

// File: tb/tb_led_pattern_sequencer.sv
// ============================================================================
// tb_led_pattern_sequencer : vector table plus multi-cycle prescaler sequences
// Revision                 : 1.0
// ============================================================================
`default_nettype none

module tb_led_pattern_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       dir = 1'b0;
  logic       hold = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] period = 8'd0;
  logic [3:0] leds;
  logic       step;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic       rst;
    logic       en;
    logic       dir;
    logic       hold;
    logic [1:0] mode;
    logic [7:0] period;
    logic [3:0] leds;
    logic       step;
  } vec_t;

  vec_t tbl[$];

  led_pattern_sequencer #(
    .N_LEDS (4),
    .CNT_W  (8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .dir    (dir),
    .hold   (hold),
    .mode   (mode),
    .period (period),
    .leds   (leds),
    .step   (step)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic r, input logic e, input logic d, input logic h,
                              input logic [1:0] m, input logic [7:0] p,
                              input logic [3:0] l, input logic s);
    vec_t v;
    v.rst = r; v.en = e; v.dir = d; v.hold = h;
    v.mode = m; v.period = p; v.leds = l; v.step = s;
    tbl.push_back(v);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [3:0] l, input logic s);
    n_vec++;
    if (leds !== l || step !== s) begin
      n_bad++;
      $display("FAIL %s: got leds=%b step=%b, expected leds=%b step=%b", nm, leds, step, l, s);
    end
  endtask

  function automatic logic [3:0] rot(input int idx);
    logic [3:0] one;
    one = 4'b0001;
    return one << (idx % 4);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // rst en dir hold mode period -> leds step (all period 0)
    add(1, 1, 0, 0, 2'd1, 8'd0, 4'b0001, 1'b0);
    add(0, 1, 0, 0, 2'd1, 8'd0, 4'b0010, 1'b1);
    add(0, 1, 0, 0, 2'd1, 8'd0, 4'b0100, 1'b1);
    add(0, 1, 0, 0, 2'd1, 8'd0, 4'b1000, 1'b1);
    add(0, 1, 1, 0, 2'd1, 8'd0, 4'b0100, 1'b1);
    add(0, 1, 1, 0, 2'd1, 8'd0, 4'b0010, 1'b1);
    add(0, 1, 0, 0, 2'd1, 8'd0, 4'b0001, 1'b1);
    add(0, 1, 1, 0, 2'd1, 8'd0, 4'b0010, 1'b1);
    add(0, 1, 1, 0, 2'd2, 8'd0, 4'b0000, 1'b1);
    add(0, 1, 1, 0, 2'd2, 8'd0, 4'b1000, 1'b1);
    add(0, 1, 1, 0, 2'd2, 8'd0, 4'b1100, 1'b1);
    add(0, 1, 1, 0, 2'd2, 8'd0, 4'b1110, 1'b1);
    add(0, 1, 1, 0, 2'd2, 8'd0, 4'b1111, 1'b1);
    add(0, 1, 1, 0, 2'd2, 8'd0, 4'b0000, 1'b1);
    add(0, 1, 1, 0, 2'd3, 8'd0, 4'b0001, 1'b1);
    add(0, 1, 1, 0, 2'd3, 8'd0, 4'b0000, 1'b1);
    add(0, 1, 1, 0, 2'd3, 8'd0, 4'b1111, 1'b1);
    add(0, 1, 1, 0, 2'd3, 8'd0, 4'b1110, 1'b1);
    add(0, 1, 1, 1, 2'd3, 8'd0, 4'b1110, 1'b0);
    add(0, 0, 1, 0, 2'd3, 8'd0, 4'b1110, 1'b0);
    add(0, 1, 1, 0, 2'd3, 8'd0, 4'b1101, 1'b1);
    add(0, 1, 0, 0, 2'd0, 8'd0, 4'b0001, 1'b1);
    add(0, 1, 0, 0, 2'd0, 8'd0, 4'b0010, 1'b1);
    add(0, 1, 1, 0, 2'd0, 8'd0, 4'b0001, 1'b1);
    add(0, 1, 1, 0, 2'd0, 8'd0, 4'b1000, 1'b1);
    add(0, 1, 0, 0, 2'd0, 8'd0, 4'b0001, 1'b1);
    add(0, 1, 0, 0, 2'd3, 8'd0, 4'b0001, 1'b1);
    add(0, 1, 0, 0, 2'd3, 8'd0, 4'b0010, 1'b1);
    add(0, 1, 0, 0, 2'd3, 8'd0, 4'b0011, 1'b1);
    add(1, 1, 0, 0, 2'd2, 8'd0, 4'b0001, 1'b0);
    add(0, 1, 0, 0, 2'd2, 8'd0, 4'b0011, 1'b1);
    add(0, 1, 0, 0, 2'd2, 8'd0, 4'b0111, 1'b1);
    add(0, 1, 0, 0, 2'd2, 8'd0, 4'b1111, 1'b1);
    add(0, 1, 0, 0, 2'd2, 8'd0, 4'b0000, 1'b1);

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; en = tbl[i].en; dir = tbl[i].dir; hold = tbl[i].hold;
      mode = tbl[i].mode; period = tbl[i].period;
      cyc();
      chk($sformatf("vec%0d", i), tbl[i].leds, tbl[i].step);
    end

    // Rotate with period 10: each pattern held 11 cycles.
    rst = 1; en = 1; dir = 0; hold = 0; mode = 2'd0; period = 8'd10;
    cyc();
    chk("p10_reset", 4'b0001, 1'b0);
    rst = 0;
    for (int e = 1; e <= 44; e++) begin
      cyc();
      chk($sformatf("p10_e%0d", e), rot(e / 11), (e % 11) == 0);
    end

    // Hold drops ticks, en=0 freezes pc at 9, resume steps after 32-9 cycles.
    rst = 1; period = 8'd31;
    cyc();
    rst = 0;
    repeat (5) cyc();
    hold = 1;
    for (int e = 0; e < 100; e++) begin
      cyc();
      chk($sformatf("hold_c%0d", e), 4'b0001, 1'b0);
    end
    hold = 0; en = 0;
    for (int e = 0; e < 20; e++) begin
      cyc();
      chk($sformatf("en0_c%0d", e), 4'b0001, 1'b0);
    end
    en = 1;
    for (int e = 1; e <= 23; e++) begin
      cyc();
      chk($sformatf("resume_e%0d", e), (e == 23) ? 4'b0010 : 4'b0001, e == 23);
    end

    // Reset beats a simultaneous tick and mode change at leds=0100, pc=7.
    rst = 1; period = 8'd7; mode = 2'd0;
    cyc();
    rst = 0;
    repeat (23) cyc();
    chk("pre_rst_0100", 4'b0100, 1'b0);
    rst = 1; mode = 2'd1;
    cyc();
    chk("rst_priority", 4'b0001, 1'b0);
    rst = 0;
    for (int e = 1; e <= 8; e++) begin
      cyc();
      chk($sformatf("post_rst_e%0d", e), (e == 8) ? 4'b0010 : 4'b0001, e == 8);
    end

    // Shrinking period below the current count ticks on the next cycle.
    rst = 1; mode = 2'd0; period = 8'd10;
    cyc();
    rst = 0;
    repeat (8) cyc();
    chk("pc8_before", 4'b0001, 1'b0);
    period = 8'd3;
    cyc();
    chk("period_shrink", 4'b0010, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_led_pattern_sequencer

`default_nettype wire
